// File: rtl/serial_sub_pkg.sv
// Shared definitions for the serial subtractor: FSM state encoding and
// the slice-counter width helper.
package serial_sub_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Counter width for n slices: clog2(n), never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_sub_slice.sv
// SLICE-bit ripple chain of 1-bit full adders computing a_s + ~b_s + cin.
// c_msb_in is the carry entering the top bit, used for signed overflow.
module sub_slice #(
    parameter int unsigned SLICE = 1
) (
    input  logic [SLICE-1:0] a_s,
    input  logic [SLICE-1:0] b_s,
    input  logic             cin,
    output logic [SLICE-1:0] d_s,
    output logic             cout,
    output logic             c_msb_in
);

    logic [SLICE-1:0] nb;

    assign nb = ~b_s;

    // Ripple the carry bit by bit through the slice.
    always_comb begin : ripple
        logic c;
        c        = cin;
        c_msb_in = cin;
        d_s      = '0;
        for (int unsigned i = 0; i < SLICE; i++) begin
            if (i == SLICE - 1) begin
                c_msb_in = c;
            end
            d_s[i] = a_s[i] ^ nb[i] ^ c;
            c      = (a_s[i] & nb[i]) | (c & (a_s[i] ^ nb[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle two's-complement subtractor: diff = a - b = a + ~b + 1,
// SLICE bits per clock with a registered carry between slices.
// Optional zero-result flag: define SERIAL_SUBTRACTOR_ZERO_FLAG_EN.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             carryout,
    output logic             overflow,
    output logic             busy,
    output logic             done
`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
   ,output logic             zero
`endif
);

    localparam int unsigned N  = WIDTH / SLICE;
    localparam int unsigned CW = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if (WIDTH % SLICE != 0) begin : g_bad_slice
        $error("serial_subtractor: SLICE must divide WIDTH");
    end

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, res_q, res_d;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q, co_q, ov_q, busy_q, done_q;
    logic [SLICE-1:0] d_s;
    logic             s_cout, s_cmsb;

    sub_slice #(.SLICE(SLICE)) u_slice (
        .a_s      (a_q[SLICE-1:0]),
        .b_s      (b_q[SLICE-1:0]),
        .cin      (carry_q),
        .d_s      (d_s),
        .cout     (s_cout),
        .c_msb_in (s_cmsb)
    );

    // Result register shifts right; the new slice enters at the MSB end.
    always_comb begin
        res_d                   = res_q >> SLICE;
        res_d[WIDTH-1 -: SLICE] = d_s;
    end

`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
    logic zero_q;
    assign zero = zero_q;

    // Zero flag updates only on the completing edge and holds like diff.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zero_q <= 1'b0;
        end else if (state_q == ST_RUN && cnt_q == LAST) begin
            zero_q <= (res_d == '0);
        end
    end
`endif

    // Control FSM plus datapath registers; outputs change only on completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= 1'b1;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_q     <= a_q >> SLICE;
                    b_q     <= b_q >> SLICE;
                    res_q   <= res_d;
                    carry_q <= s_cout;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        diff_q  <= res_d;
                        co_q    <= s_cout;
                        ov_q    <= s_cmsb ^ s_cout;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign diff     = diff_q;
    assign carryout = co_q;
    assign overflow = ov_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Multi-cycle two's-complement subtractor computing diff = a - b as a + ~b + 1. It processes SLICE bits per clock, with a registered borrow/carry between slices, and uses a start/busy/done handshake. It complements the combinational 32-bit adder. It targets area-constrained datapaths where latency is acceptable, and its flag semantics (carryout, overflow) match the adder.

Parameters:
WIDTH, 32, operand and result width in bits.
SLICE, 1, bits processed per cycle. Must divide WIDTH; checked by a generate-time error.

Ports:
clk  input  1  single clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  request. Sampled only when busy=0.
a  input  WIDTH  minuend. Captured on the accepting edge.
b  input  WIDTH  subtrahend. Captured on the accepting edge.
diff  output  WIDTH  a - b, modulo 2^WIDTH.
carryout  output  1  carry out of the MSB of a + ~b + 1. 1 = no unsigned borrow (a >= b unsigned).
overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.
busy  output  1  high while a subtraction is in progress.
done  output  1  single-cycle pulse marking that results are valid.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (reset).
- Reset values: diff=0, carryout=0, overflow=0, busy=0, done=0, FSM=IDLE, internal carry=0, slice counter=0.
- Reset asserted mid-operation: aborts immediately to the reset values above. No done pulse for the aborted request.
- States: IDLE and RUN. N = WIDTH/SLICE.
- IDLE + start=1 on edge k:
  - latch a into shift register A and b into shift register B;
  - carry <= 1, counter <= 0;
  - go to RUN; busy=1 from edge k.
- RUN, each edge:
  - compute A[SLICE-1:0] + ~B[SLICE-1:0] + carry through a SLICE-bit ripple chain;
  - shift the slice result into the result register from the MSB side;
  - shift A and B right by SLICE;
  - carry <= slice carry out;
  - counter++.
- Final slice (counter = N-1), same edge:
  - diff <= full result; carryout <= chain carry out; overflow <= carry into bit SLICE-1 XOR chain carry out;
  - done <= 1; busy <= 0; go to IDLE.
- Latency: done is high during the cycle following edge k+N. For SLICE=1, WIDTH=32 that is 32 edges after acceptance.
- Done pulse: exactly one cycle wide.
- Output hold: diff, carryout and overflow hold their values until the next completion or reset. They do not change during RUN; the result is accumulated in an internal register.
- start while busy=1: ignored. No queueing, and the operands are not recaptured.
- start in the cycle done=1: accepted, since the FSM is already IDLE. Back-to-back throughput is one result per N+1 cycles... specifically, a start held high continuously yields a new done every N+1 cycles.
- a and b may change freely after acceptance.
- Wrap-around: diff is always modulo 2^WIDTH. Flags follow the adder convention exactly.

Optional Feature:
Macro SERIAL_SUBTRACTOR_ZERO_FLAG_EN.
- Defined: adds output port zero (1 bit). Reset value 0. Updated on the completing edge to 1 iff the result equals 0, otherwise 0. Held like diff.
- Undefined: port absent; no zero-detect logic.

Decomposition:
- Shared package (serial_sub_pkg): state encoding constants ST_IDLE=0 and ST_RUN=1, and counter width derived as clog2(WIDTH/SLICE), minimum 1.
- One natural sub-module: sub_slice. It is a SLICE-bit ripple of 1-bit full adders with inputs a_s, b_s (inverted internally) and cin, and outputs d_s, cout and c_msb_in for overflow.
- The FSM, shift registers and counter stay in the top module.

Test Plan:
- WIDTH=32, SLICE=1; a=5, b=3; pulse start: done exactly 32 cycles after acceptance; diff=0x00000002, carryout=1, overflow=0.
- a=0, b=1: diff=0xFFFFFFFF, carryout=0, overflow=0.
- a=0x80000000, b=1: diff=0x7FFFFFFF, carryout=1, overflow=1.
- a=0x7FFFFFFF, b=0xFFFFFFFF: diff=0x80000000, carryout=0, overflow=1.
- Busy and reset behaviour, a=9, b=4:
  - start again at cycle 5 with a=1, b=1: ignored; the final diff is 5.
  - a new run with reset asserted at cycle 10: all outputs 0, busy=0, no done.
  - start after deassert: the correct result arrives 32 cycles later.
- SLICE=4 build with SERIAL_SUBTRACTOR_ZERO_FLAG_EN defined:
  - a=7, b=7: done 8 cycles after acceptance; diff=0, carryout=1, overflow=0, zero=1.
  - start held high: a done every 9 cycles.
